// File: rtl/bench_hub_pkg.sv
// Shared types for the benchmark output hub: operating modes and a helper
// that folds the reserved mode encoding onto direct mode.
package bench_hub_pkg;

  localparam int HUB_MODE_W = 2;

  typedef enum logic [1:0] {
    HUB_DIRECT = 2'b00,
    HUB_SCAN   = 2'b01,
    HUB_FREEZE = 2'b10,
    HUB_RSVD   = 2'b11
  } hub_mode_t;

  // The reserved encoding behaves exactly like direct mode.
  function automatic hub_mode_t norm_mode(input logic [HUB_MODE_W-1:0] m);
    return (m == 2'b11) ? HUB_DIRECT : hub_mode_t'(m);
  endfunction

endpackage

// File: rtl/bench_hub_scan_timer.sv
// Dwell timer for auto-scan. Counts 0..DWELL-1 while enabled and pulses tick
// (combinationally) on the terminal count.
//   clr     : next count is 0, no tick this cycle (takes priority)
//   restart : treat the current count as 0 this cycle (first cycle of a scan run)
//   en      : advance; hold otherwise
module bench_hub_scan_timer #(
  parameter int DWELL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] eff_cnt;

  // Effective count for this cycle and terminal-count detection.
  always_comb begin
    eff_cnt = restart ? '0 : dwell_cnt;
    tick    = en && !clr && (eff_cnt == LAST);
  end

  // Dwell counter register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      dwell_cnt <= '0;
    end else if (clr) begin
      dwell_cnt <= '0;
    end else if (en) begin
      dwell_cnt <= tick ? '0 : eff_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bench_output_hub.sv
// Benchmark output hub: routes one of N_CH W-bit result buses to a registered
// output. Channel is latched by strobe, auto-scanned on a dwell timer, or the
// output is frozen.
// Optional feature macro: BENCH_HUB_CHANGE_EN adds per-channel change flags
// (chg_flags) with a clear input (chg_clr).
module bench_output_hub
  import bench_hub_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int DWELL = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*W-1:0]         ch_data,
  input  logic [$clog2(N_CH)-1:0]   sel,
  input  logic                      sel_load,
  input  logic [HUB_MODE_W-1:0]     mode,
  output logic [W-1:0]              out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic                      out_valid,
  output logic                      scan_wrap,
  output logic                      sel_err
`ifdef BENCH_HUB_CHANGE_EN
  ,
  input  logic                      chg_clr,
  output logic [N_CH-1:0]           chg_flags
`endif
);

  localparam int SEL_W = $clog2(N_CH);
  // One extra bit so the range check works even when N_CH is a power of two.
  localparam logic [SEL_W:0]   N_CH_CMP = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  hub_mode_t        cur_mode;
  logic             scan_on;
  logic             was_scan;
  logic             sel_ok;
  logic             sel_bad;
  logic             tick;
  logic             timer_clr;
  logic [SEL_W-1:0] active_sel;
  logic [SEL_W-1:0] next_sel;
  logic             wrap_next;
  logic [W-1:0]     ch [N_CH];

  // Unpack the flat channel bus into one word per channel.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch[k] = ch_data[k*W +: W];
    end
  end

  // Mode decode, strobe validation and next-channel selection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_sel  = active_sel;
    wrap_next = 1'b0;
    cur_mode  = norm_mode(mode);
    scan_on   = (cur_mode == HUB_SCAN);
    sel_ok    = sel_load && ({1'b0, sel} <  N_CH_CMP);
    sel_bad   = sel_load && ({1'b0, sel} >= N_CH_CMP);
    // Direct mode parks the timer at 0; a valid strobe in scan restarts it.
    timer_clr = (cur_mode == HUB_DIRECT) || (scan_on && sel_ok);
    if (sel_ok) begin
      next_sel = sel;
    end else if (tick) begin
      wrap_next = (active_sel == SEL_LAST);
      next_sel  = wrap_next ? '0 : active_sel + 1'b1;
    end
  end

  bench_hub_scan_timer #(
    .DWELL(DWELL)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (scan_on),
    .restart (!was_scan),
    .clr     (timer_clr),
    .tick    (tick)
  );

  // Select register, output register and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_sel <= '0;
      was_scan   <= 1'b0;
      scan_wrap  <= 1'b0;
      sel_err    <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
    end else begin
      active_sel <= next_sel;
      was_scan   <= scan_on;
      scan_wrap  <= wrap_next;
      sel_err    <= sel_bad;
      if (cur_mode != HUB_FREEZE) begin
        out_data  <= ch[active_sel];
        out_ch    <= active_sel;
        out_valid <= 1'b1;
      end
    end
  end

`ifdef BENCH_HUB_CHANGE_EN
  logic [W-1:0] shadow [N_CH];

  // Previous-cycle shadow of each channel and sticky change flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small register array is reset explicitly because the first
      // comparison after reset must be against a known zero value.
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= '0;
      end
      chg_flags <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        shadow[k]    <= ch[k];
        chg_flags[k] <= (ch[k] != shadow[k]) || (chg_flags[k] && !chg_clr);
      end
    end
  end
`endif

endmodule
